phase_sequence_monitor: RTL

- Receive-side companion to the five-phase clock generator. Samples the 5-bit one-hot Phases bus every CLK.
- Locks onto the phase rotation, decodes it to a stage index and counts completed instruction cycles.
- Flags any illegal or out-of-order phase pattern with a sticky error.
- Sits beside the multi-cycle control path. Downstream logic consumes its stage index and error flag.

---
 rtl/phase_sequence_monitor_pkg.sv | 24 ++
 rtl/phase_sequence_monitor_if.sv | 24 ++
 rtl/phase_sequence_monitor_decode.sv | 23 ++
 rtl/phase_sequence_monitor.sv | 119 +++++++++++
 4 files changed

// File: rtl/phase_sequence_monitor_pkg.sv
// Shared constants and types for the phase sequence monitor and its phase decoder.
package phase_sequence_monitor_pkg;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } monState_t;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_ONEHOT = 2'b01,
        ERR_ORDER  = 2'b10
    } errCode_t;

    localparam logic [2:0] STAGE_NONE = 3'd7;
    localparam logic [2:0] LAST_STAGE = 3'd4;

    // Phase that must follow idx in a legal rotation (4 wraps back to 0).
    function automatic logic [2:0] nextIndex(input logic [2:0] idx);
        return (idx == LAST_STAGE) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/phase_sequence_monitor_if.sv
// Phase bus plus monitor status outputs; the master drives phases, the slave is the monitor.
interface phase_sequence_monitor_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Phases;
    logic             ClrErr;
    logic [2:0]       Stage;
    logic             Locked;
    logic             InstrDone;
    logic [CNT_W-1:0] InstrCount;
    logic             PhaseErr;
    logic [1:0]       ErrCode;
    logic [4:0]       ErrPhase;

    modport master (
        output Phases, ClrErr,
        input  Stage, Locked, InstrDone, InstrCount, PhaseErr, ErrCode, ErrPhase
    );

    modport slave (
        input  Phases, ClrErr,
        output Stage, Locked, InstrDone, InstrCount, PhaseErr, ErrCode, ErrPhase
    );
endinterface

// File: rtl/phase_sequence_monitor_decode.sv
// Combinational one-hot phase decoder; any pattern that is not exactly one bit is invalid.
module phase_onehot_decode
    import phase_sequence_monitor_pkg::*;
(
    input  logic [4:0] phases,
    output logic       valid,
    output logic [2:0] idx
);

    always_comb begin
        valid = 1'b1;
        idx   = STAGE_NONE;
        case (phases)
            5'b00001: idx = 3'd0;
            5'b00010: idx = 3'd1;
            5'b00100: idx = 3'd2;
            5'b01000: idx = 3'd3;
            5'b10000: idx = 3'd4;
            default:  valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/phase_sequence_monitor.sv
// Locks onto the five-phase rotation, reports the stage, counts rotations and latches the first phase error.
module phase_sequence_monitor
    import phase_sequence_monitor_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    phase_sequence_monitor_if.slave  bus
);

    monState_t        state, stateNext;
    logic       [2:0] expected, expectedNext;
    logic       [2:0] stage, stageNext;
    logic             locked, lockedNext;
    logic             done, doneNext;
    logic [CNT_W-1:0] instrCount, countNext;
    logic             phaseErr, errNext;
    errCode_t         errCode, codeNext;
    logic       [4:0] errPhase, errPhaseNext;

    logic             sampleValid;
    logic       [2:0] sampleIdx;

    phase_onehot_decode decoder (
        .phases (bus.Phases),
        .valid  (sampleValid),
        .idx    (sampleIdx)
    );

    // Every output is a register so Phases never reaches an output combinationally.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= UNSYNC;
            expected   <= 3'd0;
            stage      <= STAGE_NONE;
            locked     <= 1'b0;
            done       <= 1'b0;
            instrCount <= '0;
            phaseErr   <= 1'b0;
            errCode    <= ERR_NONE;
            errPhase   <= 5'b00000;
        end else begin
            state      <= stateNext;
            expected   <= expectedNext;
            stage      <= stageNext;
            locked     <= lockedNext;
            done       <= doneNext;
            instrCount <= countNext;
            phaseErr   <= errNext;
            errCode    <= codeNext;
            errPhase   <= errPhaseNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            UNSYNC:  if (bus.Phases == 5'b00001) stateNext = LOCKED;
            LOCKED:  if (!sampleValid || (sampleIdx != expected)) stateNext = FAULT;
            FAULT:   if (bus.ClrErr) stateNext = UNSYNC;
            default: stateNext = UNSYNC;
        endcase
    end

    // ClrErr only matters in FAULT; a clear never re-locks in the same cycle.
    always_comb begin
        stageNext    = STAGE_NONE;
        lockedNext   = 1'b0;
        doneNext     = 1'b0;
        countNext    = instrCount;
        errNext      = phaseErr;
        codeNext     = errCode;
        errPhaseNext = errPhase;
        expectedNext = expected;
        case (state)
            UNSYNC: begin
                if (bus.Phases == 5'b00001) begin
                    stageNext    = 3'd0;
                    lockedNext   = 1'b1;
                    expectedNext = nextIndex(3'd0);
                end
            end
            LOCKED: begin
                if (sampleValid && (sampleIdx == expected)) begin
                    stageNext    = sampleIdx;
                    lockedNext   = 1'b1;
                    expectedNext = nextIndex(sampleIdx);
                    if (sampleIdx == LAST_STAGE) begin
                        doneNext  = 1'b1;
                        countNext = instrCount + 1'b1;
                    end
                end else begin
                    errNext      = 1'b1;
                    codeNext     = sampleValid ? ERR_ORDER : ERR_ONEHOT;
                    errPhaseNext = bus.Phases;
                end
            end
            FAULT: begin
                if (bus.ClrErr) begin
                    errNext      = 1'b0;
                    codeNext     = ERR_NONE;
                    errPhaseNext = 5'b00000;
                    expectedNext = 3'd0;
                end
            end
            default: ;
        endcase
    end

    assign bus.Stage      = stage;
    assign bus.Locked     = locked;
    assign bus.InstrDone  = done;
    assign bus.InstrCount = instrCount;
    assign bus.PhaseErr   = phaseErr;
    assign bus.ErrCode    = errCode;
    assign bus.ErrPhase   = errPhase;

endmodule
